// File: rtl/ddram_wr_fifo.sv
// Write buffer between screen_rotate and the DDRAM port: drops on overflow and
// merges byte-lane half-writes to the same address into the tail entry.
module ddram_wr_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter bit          MERGE      = 1'b1
) (
    input  logic                  CLK_VIDEO,
    input  logic                  reset,
    input  logic                  in_we,
    input  logic [28:0]           in_addr,
    input  logic [63:0]           in_din,
    input  logic [7:0]            in_be,
    input  logic                  DDRAM_BUSY,
    output logic                  DDRAM_WE,
    output logic [28:0]           DDRAM_ADDR,
    output logic [63:0]           DDRAM_DIN,
    output logic [7:0]            DDRAM_BE,
    output logic [7:0]            DDRAM_BURSTCNT,
    output logic                  DDRAM_RD,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow,
    output logic [15:0]           drop_cnt,
    input  logic                  clr_status
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] Full = (DEPTH_LOG2 + 1)'(Depth);

    logic [28:0]           addr_q [Depth];
    logic [63:0]           data_q [Depth];
    logic [7:0]            be_q   [Depth];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q, tail_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic [15:0]           drop_cnt_q;

    logic        beat, pop, merge, push_req, push, drop;
    logic [63:0] merged_data;

    always_comb begin
        tail_ptr = wr_ptr_q - 1'b1;
        beat     = in_we && (in_be != 8'h00);
        pop      = (count_q != '0) && !DDRAM_BUSY;
        // With two or more entries the tail can never be the head being popped.
        merge    = MERGE && beat && (count_q >= (DEPTH_LOG2 + 1)'(2))
                   && (in_addr == addr_q[tail_ptr]);
        push_req = beat && !merge;
        push     = push_req && ((count_q < Full) || pop);
        drop     = push_req && !push;
        merged_data = data_q[tail_ptr];
        for (int i = 0; i < 8; i++) begin
            if (in_be[i]) merged_data[8*i +: 8] = in_din[8*i +: 8];
        end
    end

    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) begin
                addr_q[wr_ptr_q] <= in_addr;
                data_q[wr_ptr_q] <= in_din;
                be_q[wr_ptr_q]   <= in_be;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (merge) begin
                data_q[tail_ptr] <= merged_data;
                be_q[tail_ptr]   <= be_q[tail_ptr] | in_be;
            end
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (clr_status) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign DDRAM_WE       = (count_q != '0);
    assign DDRAM_ADDR     = addr_q[rd_ptr_q];
    assign DDRAM_DIN      = data_q[rd_ptr_q];
    assign DDRAM_BE       = be_q[rd_ptr_q];
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = 1'b0;
    assign fill           = count_q;
    assign overflow       = overflow_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_ddram_wr_fifo.sv
// Directed self-checking bench for ddram_wr_fifo (DEPTH_LOG2=4, MERGE=1).
module tb_ddram_wr_fifo;

    logic        CLK_VIDEO = 1'b0;
    logic        reset = 1'b1;
    logic        in_we = 1'b0;
    logic [28:0] in_addr = '0;
    logic [63:0] in_din = '0;
    logic [7:0]  in_be = '0;
    logic        DDRAM_BUSY = 1'b0;
    logic        DDRAM_WE;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [7:0]  DDRAM_BURSTCNT;
    logic        DDRAM_RD;
    logic [4:0]  fill;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_status = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [28:0] last_addr;

    ddram_wr_fifo #(.DEPTH_LOG2(4), .MERGE(1'b1)) dut (
        .CLK_VIDEO(CLK_VIDEO), .reset(reset), .in_we(in_we), .in_addr(in_addr),
        .in_din(in_din), .in_be(in_be), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_WE(DDRAM_WE),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_RD(DDRAM_RD), .fill(fill),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_status(clr_status)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_VIDEO);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the write edge.
    task automatic wr(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
        in_we = 1'b1; in_addr = a; in_din = d; in_be = be;
        tick();
        in_we = 1'b0; in_be = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " we"}, 64'(DDRAM_WE), 64'd0);
        check({tag, " addr"}, 64'(DDRAM_ADDR), 64'd0);
        check({tag, " din"}, DDRAM_DIN, 64'd0);
        check({tag, " be"}, 64'(DDRAM_BE), 64'd0);
        check({tag, " fill"}, 64'(fill), 64'd0);
        check({tag, " ovf"}, 64'(overflow), 64'd0);
        check({tag, " drops"}, 64'(drop_cnt), 64'd0);
        check({tag, " burst"}, 64'(DDRAM_BURSTCNT), 64'd1);
        check({tag, " rd"}, 64'(DDRAM_RD), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // 1: single write through an empty FIFO
        wr(29'h100, 64'h11223344, 8'h0F);
        check("t1 we", 64'(DDRAM_WE), 64'd1);
        check("t1 addr", 64'(DDRAM_ADDR), 64'h100);
        check("t1 be", 64'(DDRAM_BE), 64'h0F);
        check("t1 din", DDRAM_DIN, 64'h11223344);
        tick();
        check("t1 fill", 64'(fill), 64'd0);
        check("t1 we0", 64'(DDRAM_WE), 64'd0);

        // 2: half-write merge while stalled
        DDRAM_BUSY = 1'b1;
        wr(29'h200, 64'h11111111, 8'h0F);
        wr(29'h201, 64'h55667788, 8'h0F);
        wr(29'h201, 64'hAABBCCDD_00000000, 8'hF0);
        check("t2 fill", 64'(fill), 64'd2);
        check("t2 head", 64'(DDRAM_ADDR), 64'h200);
        DDRAM_BUSY = 1'b0;
        tick();
        check("t2 fill1", 64'(fill), 64'd1);
        check("t2 addrB", 64'(DDRAM_ADDR), 64'h201);
        check("t2 beB", 64'(DDRAM_BE), 64'hFF);
        check("t2 dinB", DDRAM_DIN, 64'hAABBCCDD55667788);
        tick();
        check("t2 empty", 64'(DDRAM_WE), 64'd0);

        // 3: overflow with 20 distinct writes
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 20; i++) wr(29'h300 + 29'(i), 64'hA0 + 64'(i), 8'hFF);
        check("t3 fill", 64'(fill), 64'd16);
        check("t3 ovf", 64'(overflow), 64'd1);
        check("t3 drops", 64'(drop_cnt), 64'd4);
        check("t3 head addr", 64'(DDRAM_ADDR), 64'h300);
        check("t3 head din", DDRAM_DIN, 64'hA0);

        // 4: full FIFO, pop and push on the same edge
        DDRAM_BUSY = 1'b0;
        wr(29'h400, 64'hBEEF, 8'hFF);
        check("t4 fill", 64'(fill), 64'd16);
        check("t4 drops", 64'(drop_cnt), 64'd4);
        check("t4 head", 64'(DDRAM_ADDR), 64'h301);
        last_addr = '0;
        for (int i = 0; i < 40; i++) begin
            if (fill == 5'd1) last_addr = DDRAM_ADDR;
            if (fill == 5'd0) break;
            tick();
        end
        check("t4 drained", 64'(fill), 64'd0);
        check("t4 last", 64'(last_addr), 64'h400);

        // 5: asynchronous reset mid-operation
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 5; i++) wr(29'h500 + 29'(i), 64'h5, 8'hFF);
        check("t5 fill", 64'(fill), 64'd5);
        #3 reset = 1'b1;
        #1 check_reset_state("t5 async");
        #2 reset = 1'b0;
        DDRAM_BUSY = 1'b0;
        @(posedge CLK_VIDEO);
        #1;
        wr(29'h600, 64'h66, 8'h01);
        check("t5 we", 64'(DDRAM_WE), 64'd1);
        check("t5 addr", 64'(DDRAM_ADDR), 64'h600);
        tick();
        check("t5 empty", 64'(fill), 64'd0);

        // 6: clr_status priority and drop counter saturation
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 16; i++) wr(29'h700 + 29'(i), 64'h7, 8'hFF);
        clr_status = 1'b1;
        wr(29'h710, 64'h7, 8'hFF);
        clr_status = 1'b0;
        check("t6 clr ovf", 64'(overflow), 64'd0);
        check("t6 clr drops", 64'(drop_cnt), 64'd0);
        wr(29'h711, 64'h7, 8'hFF);
        check("t6 ovf", 64'(overflow), 64'd1);
        check("t6 drops", 64'(drop_cnt), 64'd1);
        in_we = 1'b1; in_addr = 29'h712; in_be = 8'hFF;
        repeat (70000) @(posedge CLK_VIDEO);
        #1;
        in_we = 1'b0; in_be = '0;
        check("t6 sat", 64'(drop_cnt), 64'hFFFF);
        check("t6 fill", 64'(fill), 64'd16);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("t6 clr2", 64'(drop_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
